// File: rtl/pipeline_pkg.sv
// Shared types and encodings for the RV32I pipeline control logic.
package pipeline_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        FILL   = 2'd2
    } hz_state_t;

    localparam logic [1:0] FWD_REG     = 2'b00;
    localparam logic [1:0] FWD_W       = 2'b01;
    localparam logic [1:0] FWD_M       = 2'b10;
    localparam logic [1:0] RESULT_LOAD = 2'b01;

endpackage

// File: rtl/hazard_unit_fwd_sel.sv
// EX-stage operand forward select for one source register; M-stage result wins over W.
module fwd_sel
    import pipeline_pkg::*;
(
    input  logic [4:0] rs_e_i,
    input  logic [4:0] rd_m_i,
    input  logic [4:0] rd_w_i,
    input  logic       reg_write_m_i,
    input  logic       reg_write_w_i,
    output logic [1:0] fwd_o
);

    always_comb begin
        fwd_o = FWD_REG;
        if (reg_write_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs_e_i)) begin
            fwd_o = FWD_M;
        end else if (reg_write_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs_e_i)) begin
            fwd_o = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: stall/flush/forward generation plus a data-cache
// refill FSM that freezes every pipeline register while a line is fetched.
module hazard_unit
    import pipeline_pkg::*;
#(
    parameter int LINE_WORDS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [4:0]                    Rs1D,
    input  logic [4:0]                    Rs2D,
    input  logic [4:0]                    Rs1E,
    input  logic [4:0]                    Rs2E,
    input  logic [4:0]                    RdE,
    input  logic [4:0]                    RdM,
    input  logic [4:0]                    RdW,
    input  logic                          RegWriteM,
    input  logic                          RegWriteW,
    input  logic [1:0]                    ResultSrcE,
    input  logic                          PCSrcE,
    input  logic                          MissM,
    input  logic                          mem_rvalid,
    output logic                          StallF,
    output logic                          StallD,
    output logic                          StallE,
    output logic                          StallM,
    output logic                          StallW,
    output logic                          FlushD,
    output logic                          FlushE,
    output logic [1:0]                    ForwardAE,
    output logic [1:0]                    ForwardBE,
    output logic                          mem_req,
    output logic [$clog2(LINE_WORDS)-1:0] refill_idx,
    output logic                          line_done,
    output logic [31:0]                   miss_count
);

    localparam int IW = $clog2(LINE_WORDS);
    localparam logic [IW-1:0] LAST_BEAT = IW'(LINE_WORDS - 1);

    hz_state_t     state_q, state_d;
    logic [IW-1:0] beat_cnt_q, beat_cnt_d;
    logic [31:0]   miss_count_q, miss_count_d;
    logic          miss_stall;
    logic          lw_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            miss_count_q <= miss_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        miss_count_d = miss_count_q;
        unique case (state_q)
            IDLE: begin
                if (MissM) begin
                    state_d      = REFILL;
                    miss_count_d = miss_count_q + 32'd1;
                end
            end
            REFILL: begin
                if (mem_rvalid) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d    = FILL;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            FILL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A taken branch squashes Decode, so it masks the load-use stall; a miss
    // freezes everything including a pending branch until the line is in.
    assign miss_stall = MissM | (state_q != IDLE);
    assign lw_stall   = (ResultSrcE == RESULT_LOAD) & (RdE != 5'd0)
                      & ((RdE == Rs1D) | (RdE == Rs2D)) & ~PCSrcE;

    assign StallF = miss_stall | lw_stall;
    assign StallD = miss_stall | lw_stall;
    assign StallE = miss_stall;
    assign StallM = miss_stall;
    assign StallW = miss_stall;
    assign FlushD = ~miss_stall & PCSrcE;
    assign FlushE = ~miss_stall & (lw_stall | PCSrcE);

    fwd_sel u_fwd_a (
        .rs_e_i        (Rs1E),
        .rd_m_i        (RdM),
        .rd_w_i        (RdW),
        .reg_write_m_i (RegWriteM),
        .reg_write_w_i (RegWriteW),
        .fwd_o         (ForwardAE)
    );

    fwd_sel u_fwd_b (
        .rs_e_i        (Rs2E),
        .rd_m_i        (RdM),
        .rd_w_i        (RdW),
        .reg_write_m_i (RegWriteM),
        .reg_write_w_i (RegWriteW),
        .fwd_o         (ForwardBE)
    );

    assign mem_req    = (state_q == REFILL);
    assign line_done  = (state_q == FILL);
    assign refill_idx = beat_cnt_q;
    assign miss_count = miss_count_q;

endmodule
